mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; the product is 2*WIDTH bits.
REQ-002 The block SHALL have parameter ITERS, default WIDTH, number of shift-add iterations.
REQ-003 Port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port Rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port start, input, 1: request a multiply; accepted only when ready=1.
REQ-006 Port signed_op, input, 1: 1 = two's-complement operands (mult), 0 = unsigned (multu).
REQ-007 Port opA, input, WIDTH: multiplicand.
REQ-008 Port opB, input, WIDTH: multiplier.
REQ-009 Port ready, output, 1: high in IDLE and DONE states; start is accepted when ready=1.
REQ-010 Port busy, output, 1: high in CALC and FIX states.
REQ-011 Port multResult, output, 2*WIDTH: product, {HI, LO}; feeds the HI/LO write unit.
REQ-012 Port result_valid, output, 1: one-cycle pulse when multResult is updated.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE.
REQ-014 IDLE->CALC on start=1. CALC->FIX after ITERS iterations. FIX->DONE always. DONE->CALC if start=1, else DONE->IDLE.
REQ-015 On acceptance, opA, opB and signed_op SHALL be captured. Later changes to the inputs SHALL NOT affect the operation in progress.
REQ-016 If signed_op=1, the captured operands SHALL be replaced by their magnitudes, and the XOR of their sign bits SHALL be stored as neg_flag. If signed_op=0, neg_flag=0.
REQ-017 CALC SHALL perform one radix-2 shift-add step per cycle:
- add the multiplicand to the upper accumulator if the multiplier LSB is 1;
- shift {carry, acc} right by one;
- use a (log2(ITERS)+1)-bit iteration counter.
REQ-018 FIX SHALL two's-complement negate the full 2*WIDTH-bit accumulator when neg_flag=1, else pass it through unchanged.
REQ-019 On the FIX->DONE edge, multResult SHALL be loaded, and result_valid SHALL be high for exactly the DONE cycle.
REQ-020 Latency: result_valid SHALL be high in the cycle following the (ITERS+1)th rising edge after the accepting edge (33 edges for WIDTH=32).
REQ-021 multResult SHALL hold its value until the next FIX->DONE load, including while a new operation is busy.
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 start during DONE SHALL be accepted in that same cycle (back-to-back operation), with no IDLE bubble.
REQ-024 Signed 0x80000000 x 0x80000000 SHALL produce 0x4000000000000000: the magnitude of the most negative value SHALL be handled as unsigned WIDTH bits.
REQ-025 The result SHALL be exact modulo 2^(2*WIDTH); no overflow indication is produced.

Reset
REQ-026 Rst_n=0 SHALL asynchronously force:
- state = IDLE;
- multResult = 0, result_valid = 0, busy = 0, ready = 1;
- internal accumulator, counter and neg_flag = 0.
REQ-027 Reset asserted mid-CALC or mid-FIX SHALL abort the operation; no result_valid pulse SHALL follow.
REQ-028 After Rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-029 A package mult_pkg SHALL hold the state enumeration, the default WIDTH constant and the ITERS constant.
REQ-030 The two's-complement negate SHALL be a sub-module twos_neg (parameterised width, combinational). It SHALL be used for the operand magnitudes and for the FIX correction.
REQ-031 All sequential logic SHALL reside in mult_seq. Total RTL SHALL be about 150-250 lines.

Verification
REQ-032 Unsigned: opA=0xFFFFFFFF, opB=0xFFFFFFFF, signed_op=0 -> multResult=0xFFFFFFFE00000001, result_valid pulse 33 edges after acceptance.
REQ-033 Signed: opA=0xFFFFFFFF (-1), opB=0x00000007 -> 0xFFFFFFFFFFFFFFF9. Also 0x80000000 x 0x80000000 -> 0x4000000000000000.
REQ-034 Back-to-back: start held high with 3x5 then 6x7 -> results 15 then 42. The second is accepted in the first DONE cycle, and the valid pulses are 34 cycles apart.
REQ-035 Busy: start pulse with 2x2 at iteration 10 of 9x9 -> only 81 is produced, no second result_valid, and multResult unchanged until then.
REQ-036 Reset: Rst_n low at iteration 20 -> all outputs zero and ready=1 immediately, no result_valid. A new 4x4 then yields 16.
REQ-037 Zero/identity: 0 x 0x12345678 -> 0. Signed 0x00000001 x 0x80000000 -> 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// Imported by mult_seq and its datapath helpers.
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITERS_DEF = WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/twos_neg.sv
// Combinational two's-complement negate.
// Used for operand magnitudes and the final sign correction.
module twos_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = ~a + W'(1);

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add sequential multiplier, signed or unsigned.
// IDLE/DONE accept work, CALC iterates, FIX applies the sign.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITERS = WIDTH
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    output logic               ready,
    output logic               busy,
    output logic [2*WIDTH-1:0] multResult,
    output logic               result_valid
);

    localparam int CW = $clog2(ITERS) + 1;
    localparam int PW = 2 * WIDTH;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     res_q, res_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  neg_a, neg_b;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [PW-1:0]     neg_acc;
    logic [WIDTH:0]    sum;

    twos_neg #(.W(WIDTH)) u_neg_a (.a(opA),   .y(neg_a));
    twos_neg #(.W(WIDTH)) u_neg_b (.a(opB),   .y(neg_b));
    twos_neg #(.W(PW))    u_neg_r (.a(acc_q), .y(neg_acc));

    // The most negative value's negation is its own unsigned magnitude.
    assign mag_a = (signed_op && opA[WIDTH-1]) ? neg_a : opA;
    assign mag_b = (signed_op && opB[WIDTH-1]) ? neg_b : opB;

    // Upper half plus multiplicand, carry kept for the right shift.
    assign sum = {1'b0, acc_q[PW-1:WIDTH]}
               + (acc_q[0] ? {1'b0, mcand_q} : '0);

    assign ready        = (state_q == IDLE) || (state_q == DONE);
    assign busy         = (state_q == CALC) || (state_q == FIX);
    assign multResult   = res_q;
    assign result_valid = valid_q;

    // Next-state and datapath updates for each phase of the multiply.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        res_d   = res_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    neg_d   = signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = neg_q ? neg_acc : acc_q;
                valid_d = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a cycle-level reference model.
// Directed vectors carry hand-computed products and latencies.
module tb_mult_seq;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic [W-1:0]  opA = '0;
    logic [W-1:0]  opB = '0;
    logic          ready;
    logic          busy;
    logic [63:0]   multResult;
    logic          result_valid;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    mult_seq dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .start        (start),
        .signed_op    (signed_op),
        .opA          (opA),
        .opB          (opB),
        .ready        (ready),
        .busy         (busy),
        .multResult   (multResult),
        .result_valid (result_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        if (s) return sa * sb;
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Model: an accepted op occupies LAT edges, then shows its product.
    int          m_left = 0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_res  = '0;
    logic        m_valid = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_left  <= 0;
            m_res   <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= (m_left == 1);
            if (m_left == 1) m_res <= m_prod;
            if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (start) begin
                m_prod <= prod(signed_op, opA, opB);
                m_left <= LAT;
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("valid", 64'(result_valid), 64'(m_valid));
            chk("ready", 64'(ready), 64'(m_left == 0));
            chk("busy", 64'(busy), 64'(m_left != 0));
            chk("result", multResult, m_res);
            if (result_valid) vcount <= vcount + 1;
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input string nm);
        int n;
        @(negedge Clk);
        start = 1'b1;
        signed_op = s;
        opA = a;
        opB = b;
        @(negedge Clk);
        start = 1'b0;
        signed_op = ~s;
        opA = $urandom;
        opB = $urandom;
        wait_valid(n);
        chk({nm, "_lat"}, 64'(n), 64'd33);
        chk(nm, multResult, exp);
    endtask

    initial begin
        int n;
        int v0;

        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", multResult, 64'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, "umax");
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0007,
               64'hFFFF_FFFF_FFFF_FFF9, "neg1x7");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, "minxmin");
        run_op(1'b0, 32'h0000_0000, 32'h1234_5678,
               64'h0, "zero");
        run_op(1'b1, 32'h0000_0001, 32'h8000_0000,
               64'hFFFF_FFFF_8000_0000, "onexmin");
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, "uminxmin");
        run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005,
               64'hFFFF_FFFF_FFFF_FFF1, "m3x5");

        // Back-to-back: start held, second op accepted in DONE.
        @(negedge Clk);
        start = 1'b1;
        signed_op = 1'b0;
        opA = 32'd3;
        opB = 32'd5;
        @(negedge Clk);
        opA = 32'd6;
        opB = 32'd7;
        wait_valid(n);
        chk("b2b_lat", 64'(n), 64'd33);
        chk("b2b_first", multResult, 64'd15);
        @(negedge Clk);
        start = 1'b0;
        n = 1;
        while (!result_valid && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("b2b_gap", 64'(n), 64'd34);
        chk("b2b_second", multResult, 64'd42);

        // Busy: a start pulse mid-operation is dropped.
        repeat (3) @(negedge Clk);
        v0 = vcount;
        start = 1'b1;
        opA = 32'd9;
        opB = 32'd9;
        @(negedge Clk);
        start = 1'b0;
        repeat (10) @(negedge Clk);
        start = 1'b1;
        opA = 32'd2;
        opB = 32'd2;
        @(negedge Clk);
        start = 1'b0;
        wait_valid(n);
        chk("busy_res", multResult, 64'd81);
        repeat (45) @(negedge Clk);
        chk("busy_pulses", 64'(vcount - v0), 64'd1);
        chk("busy_hold", multResult, 64'd81);

        // Reset mid-CALC aborts the operation.
        start = 1'b1;
        opA = 32'h0000_1234;
        opB = 32'h0000_0003;
        @(negedge Clk);
        start = 1'b0;
        repeat (20) @(negedge Clk);
        v0 = vcount;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("abort_result", multResult, 64'd0);
        chk("abort_valid", 64'(result_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("abort_pulses", 64'(vcount - v0), 64'd0);
        run_op(1'b0, 32'd4, 32'd4, 64'd16, "after_rst");

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'(i);
            run_op(s, a, b, prod(s, a, b), "rand");
        end

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
